// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the write-back stage: write-back source select and
// load size codes, also used by the controller when it builds these fields.
package writeback_stage_pkg;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    // Load size; the spare code behaves as a full word
    localparam logic [1:0] LOAD_WORD = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_BYTE = 2'b10;
    localparam logic [1:0] LOAD_RSVD = 2'b11;

    typedef logic [1:0] wb_sel_t;
    typedef logic [1:0] load_size_t;

    // A reserved select code must never produce a register write
    function automatic logic wb_sel_writes(input wb_sel_t sel);
        return sel != WB_SEL_RSVD;
    endfunction

endpackage

// File: rtl/writeback_stage_load_extender.sv
// Selects the addressed little-endian lane of a loaded word and sign- or
// zero-extends it to the full datapath width. Purely combinational.
module writeback_stage_load_extender
    import writeback_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  load_size_t            load_size,
    input  logic                  load_unsigned,
    input  logic [1:0]            offset,
    output logic [DATA_WIDTH-1:0] load_value
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;
    logic        half_fill;
    logic        byte_fill;

    // Lane selection; offset[0] is ignored for halfwords (no alignment trap)
    always_comb begin
        half_lane = offset[1] ? mem_data[31:16] : mem_data[15:0];
        case (offset)
            2'd0:    byte_lane = mem_data[7:0];
            2'd1:    byte_lane = mem_data[15:8];
            2'd2:    byte_lane = mem_data[23:16];
            default: byte_lane = mem_data[31:24];
        endcase
        half_fill = ~load_unsigned & half_lane[15];
        byte_fill = ~load_unsigned & byte_lane[7];
    end

    // Extension by size; the reserved size falls through to a full word
    always_comb begin
        case (load_size)
            LOAD_HALF: load_value = {{(DATA_WIDTH-16){half_fill}}, half_lane};
            LOAD_BYTE: load_value = {{(DATA_WIDTH-8){byte_fill}}, byte_lane};
            default:   load_value = mem_data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back datapath. Drives the register
// file write port and the EX-stage forwarding tap purely from registered
// state, and counts retired instructions.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic                      in_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] in_write_reg,
    input  logic [1:0]                in_wb_sel,
    input  logic [1:0]                in_load_size,
    input  logic                      in_load_unsigned,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic [DATA_WIDTH-1:0]     in_mem_data,
    input  logic [DATA_WIDTH-1:0]     in_pc_plus4,
    output logic                      reg_write,
    output logic [REG_ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_reg,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [COUNT_WIDTH-1:0]    retired_count
);

    logic                      wb_valid;
    logic                      wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_write_reg;
    wb_sel_t                   wb_wb_sel;
    load_size_t                wb_load_size;
    logic                      wb_load_unsigned;
    logic [DATA_WIDTH-1:0]     wb_alu_result;
    logic [DATA_WIDTH-1:0]     wb_mem_data;
    logic [DATA_WIDTH-1:0]     wb_pc_plus4;
    logic [DATA_WIDTH-1:0]     load_value;

    // WB register: rst > flush > stall > capture. A stall keeps the data but
    // drops valid, so a held instruction retires exactly once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb_valid         <= 1'b0;
            wb_reg_write     <= 1'b0;
            wb_write_reg     <= '0;
            wb_wb_sel        <= WB_SEL_ALU;
            wb_load_size     <= LOAD_WORD;
            wb_load_unsigned <= 1'b0;
            wb_alu_result    <= '0;
            wb_mem_data      <= '0;
            wb_pc_plus4      <= '0;
        end else if (stall) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid         <= in_valid;
            wb_reg_write     <= in_reg_write;
            wb_write_reg     <= in_write_reg;
            wb_wb_sel        <= in_wb_sel;
            wb_load_size     <= in_load_size;
            wb_load_unsigned <= in_load_unsigned;
            wb_alu_result    <= in_alu_result;
            wb_mem_data      <= in_mem_data;
            wb_pc_plus4      <= in_pc_plus4;
        end
    end

    // Retire counter advances on every edge that sees a live WB instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_count <= '0;
        end else if (wb_valid) begin
            retired_count <= retired_count + COUNT_WIDTH'(1);
        end
    end

    writeback_stage_load_extender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extender (
        .mem_data      (wb_mem_data),
        .load_size     (wb_load_size),
        .load_unsigned (wb_load_unsigned),
        .offset        (wb_alu_result[1:0]),
        .load_value    (load_value)
    );

    // Write enable gating and write-data source mux
    always_comb begin
        reg_write = wb_valid & wb_reg_write & (wb_write_reg != '0)
                    & wb_sel_writes(wb_wb_sel);
        write_reg = wb_write_reg;
        case (wb_wb_sel)
            WB_SEL_LOAD: write_data = load_value;
            WB_SEL_LINK: write_data = wb_pc_plus4;
            default:     write_data = wb_alu_result;
        endcase
    end

    // Forwarding tap mirrors the write port
    always_comb begin
        fwd_valid = reg_write;
        fwd_reg   = write_reg;
        fwd_data  = write_data;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage with a 4-bit retire counter so wrap is reachable.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_write_reg;
    logic [1:0]  in_wb_sel;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [31:0] in_pc_plus4;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic [3:0]  retired_count;

    writeback_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .COUNT_WIDTH    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_reg_write     (in_reg_write),
        .in_write_reg     (in_write_reg),
        .in_wb_sel        (in_wb_sel),
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_alu_result    (in_alu_result),
        .in_mem_data      (in_mem_data),
        .in_pc_plus4      (in_pc_plus4),
        .reg_write        (reg_write),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .fwd_valid        (fwd_valid),
        .fwd_reg          (fwd_reg),
        .fwd_data         (fwd_data),
        .retired_count    (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        valid;
        logic        rw;
        logic [4:0]  wr;
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic        exp_rw;
        logic [4:0]  exp_wr;
        logic [31:0] exp_wd;
        string       name;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [3:0]  cnt;
        string       name;
    } exp_t;

    vec_t   tbl[$];
    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    logic       model_valid = 1'b0;
    logic [3:0] model_cnt = 4'd0;

    function automatic vec_t mk(input string name, input logic r, input logic st, input logic fl,
                                input logic v, input logic rw, input logic [4:0] wr,
                                input logic [1:0] sel, input logic [1:0] size, input logic uns,
                                input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                                input logic erw, input logic [4:0] ewr, input logic [31:0] ewd);
        vec_t t;
        t.name = name; t.rst = r; t.stall = st; t.flush = fl; t.valid = v; t.rw = rw;
        t.wr = wr; t.sel = sel; t.size = size; t.uns = uns; t.alu = alu; t.mem = mem; t.pc = pc;
        t.exp_rw = erw; t.exp_wr = ewr; t.exp_wd = ewd;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one vector after a negedge, predict, clock, then compare
    task automatic cycle(input vec_t v);
        exp_t e;
        exp_t got;
        rst = v.rst; stall = v.stall; flush = v.flush; in_valid = v.valid;
        in_reg_write = v.rw; in_write_reg = v.wr; in_wb_sel = v.sel; in_load_size = v.size;
        in_load_unsigned = v.uns; in_alu_result = v.alu; in_mem_data = v.mem; in_pc_plus4 = v.pc;
        if (v.rst) model_cnt = 4'd0;
        else if (model_valid) model_cnt = model_cnt + 4'd1;
        model_valid = !v.rst && !v.flush && !v.stall && v.valid;
        e.rw = v.exp_rw; e.wr = v.exp_wr; e.wd = v.exp_wd; e.cnt = model_cnt; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.name, ".reg_write"}, 32'(reg_write), 32'(got.rw));
        check({got.name, ".write_reg"}, 32'(write_reg), 32'(got.wr));
        check({got.name, ".write_data"}, write_data, got.wd);
        check({got.name, ".fwd_valid"}, 32'(fwd_valid), 32'(got.rw));
        check({got.name, ".fwd_reg"}, 32'(fwd_reg), 32'(got.wr));
        check({got.name, ".fwd_data"}, fwd_data, got.wd);
        check({got.name, ".retired_count"}, 32'(retired_count), 32'(got.cnt));
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] MD = 32'h80FF_7F01;

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0;
        in_write_reg = '0; in_wb_sel = '0; in_load_size = '0; in_load_unsigned = 1'b0;
        in_alu_result = '0; in_mem_data = '0; in_pc_plus4 = '0;
        @(negedge clk);

        //                   name        rst st fl v rw wr  sel    size  uns alu            mem           pc            erw ewr ewd
        tbl.push_back(mk("rst0",       1, 0, 0, 1, 1, 3,  2'b00, 2'b00, 0, 32'h1111_1111, 32'h0,        32'h0,        0, 0,  32'h0));
        tbl.push_back(mk("rst1",       1, 0, 0, 1, 1, 3,  2'b00, 2'b00, 0, 32'h1111_1111, 32'h0,        32'h0,        0, 0,  32'h0));
        tbl.push_back(mk("idle",       0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 32'h0,         32'h0,        32'h0,        0, 0,  32'h0));
        tbl.push_back(mk("alu3",       0, 0, 0, 1, 1, 3,  2'b00, 2'b00, 0, 32'h0000_1234, 32'h0,        32'h0,        1, 3,  32'h0000_1234));
        tbl.push_back(mk("lb_off3",    0, 0, 0, 1, 1, 4,  2'b01, 2'b10, 0, 32'h0000_0003, MD,           32'h0,        1, 4,  32'hFFFF_FF80));
        tbl.push_back(mk("lbu_off1",   0, 0, 0, 1, 1, 5,  2'b01, 2'b10, 1, 32'h0000_0001, MD,           32'h0,        1, 5,  32'h0000_007F));
        tbl.push_back(mk("lh_off2",    0, 0, 0, 1, 1, 6,  2'b01, 2'b01, 0, 32'h0000_0002, MD,           32'h0,        1, 6,  32'hFFFF_80FF));
        tbl.push_back(mk("lw",         0, 0, 0, 1, 1, 7,  2'b01, 2'b00, 0, 32'h0000_0002, MD,           32'h0,        1, 7,  32'h80FF_7F01));
        tbl.push_back(mk("lhu_off3",   0, 0, 0, 1, 1, 8,  2'b01, 2'b01, 1, 32'h0000_0003, MD,           32'h0,        1, 8,  32'h0000_80FF));
        tbl.push_back(mk("lh_off1",    0, 0, 0, 1, 1, 9,  2'b01, 2'b01, 0, 32'h0000_0001, MD,           32'h0,        1, 9,  32'h0000_7F01));
        tbl.push_back(mk("lb_off2",    0, 0, 0, 1, 1, 10, 2'b01, 2'b10, 0, 32'h0000_0002, MD,           32'h0,        1, 10, 32'hFFFF_FFFF));
        tbl.push_back(mk("lb_off0",    0, 0, 0, 1, 1, 11, 2'b01, 2'b10, 0, 32'h0000_0000, MD,           32'h0,        1, 11, 32'h0000_0001));
        tbl.push_back(mk("lsz_rsvd",   0, 0, 0, 1, 1, 12, 2'b01, 2'b11, 0, 32'h0000_0001, MD,           32'h0,        1, 12, 32'h80FF_7F01));
        tbl.push_back(mk("jal31",      0, 0, 0, 1, 1, 31, 2'b10, 2'b00, 0, 32'hDEAD_BEEF, 32'h0,        32'h0000_0040, 1, 31, 32'h0000_0040));
        tbl.push_back(mk("jal0",       0, 0, 0, 1, 1, 0,  2'b10, 2'b00, 0, 32'hDEAD_BEEF, 32'h0,        32'h0000_0040, 0, 0,  32'h0000_0040));
        tbl.push_back(mk("sel_rsvd",   0, 0, 0, 1, 1, 5,  2'b11, 2'b00, 0, 32'h0,         32'h0,        32'h0,        0, 5,  32'h0));
        tbl.push_back(mk("nowrite",    0, 0, 0, 1, 0, 6,  2'b00, 2'b00, 0, 32'h0000_0066, 32'h0,        32'h0,        0, 6,  32'h0000_0066));
        tbl.push_back(mk("flush_stall",0, 1, 1, 1, 1, 7,  2'b00, 2'b00, 0, 32'h0000_0077, 32'h0,        32'h0,        0, 0,  32'h0));

        foreach (tbl[i]) cycle(tbl[i]);

        // Stall after a valid instruction: data held, retires once
        cycle(mk("pre_stall",  0, 0, 0, 1, 1, 8, 2'b00, 2'b00, 0, 32'h0000_0088, 32'h0, 32'h0, 1, 8, 32'h0000_0088));
        cycle(mk("stall1",     0, 1, 0, 1, 1, 9, 2'b00, 2'b00, 0, 32'h0000_0099, 32'h0, 32'h0, 0, 8, 32'h0000_0088));
        cycle(mk("stall2",     0, 1, 0, 1, 1, 9, 2'b00, 2'b00, 0, 32'h0000_0099, 32'h0, 32'h0, 0, 8, 32'h0000_0088));
        cycle(mk("unstall",    0, 0, 0, 1, 1, 9, 2'b00, 2'b00, 0, 32'h0000_0099, 32'h0, 32'h0, 1, 9, 32'h0000_0099));

        // Reset in the middle of valid traffic
        cycle(mk("mid_alu",    0, 0, 0, 1, 1, 10, 2'b00, 2'b00, 0, 32'h0000_00AA, 32'h0, 32'h0, 1, 10, 32'h0000_00AA));
        cycle(mk("mid_rst",    1, 0, 0, 1, 1, 11, 2'b00, 2'b00, 0, 32'h0000_00BB, 32'h0, 32'h0, 0, 0,  32'h0));

        // Seventeen back-to-back retirements drive the 4-bit counter through 15 -> 0
        for (int k = 0; k < 17; k++) begin
            logic [4:0] r;
            r = 5'(k % 30 + 1);
            cycle(mk("wrap", 0, 0, 0, 1, 1, r, 2'b00, 2'b00, 0, 32'(k), 32'h0, 32'h0, 1, r, 32'(k)));
        end
        cycle(mk("wrap_end", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        check("wrap_count_model", 32'(model_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
